// File: rtl/operand_bypass_unit.sv
// ---------------------------------------------------------------------------
// operand_bypass_unit
// Operand forwarding and load-use hazard detection for the decode stage.
// Tracks the destination tags of the EX/MEM (S1) and MEM/WB (S2) instructions
// and selects register-file, ALU-result or writeback data per source operand.
//
// Ports:
//   clk, rst           core clock, async active-high reset
//   id_valid           decode holds a real instruction
//   id_src_addr/data   packed source addresses / register-file read data
//   id_dst_addr        decode destination register
//   id_wen, id_is_load decode instruction writes a register / is a load
//   flush              kill the decode instruction this cycle
//   alu_result         EX/MEM ALU result
//   wb_result          MEM/WB final result
//   src_out            forwarded operands (combinational)
//   fwd_sel            per-source select: 00 rf, 01 alu, 10 wb (combinational)
//   stall              load-use stall (combinational)
//   stall_cnt, fwd_cnt performance counters
//
// Optional feature: define BYPASS_PERF_CNT_EN to build the saturating
// stall/forward counters; otherwise both counter outputs are tied to zero.
// ---------------------------------------------------------------------------
module operand_bypass_unit #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned NSRC   = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     id_valid,
  input  logic [NSRC*ADDR_W-1:0]   id_src_addr,
  input  logic [NSRC*DATA_W-1:0]   id_src_data,
  input  logic [ADDR_W-1:0]        id_dst_addr,
  input  logic                     id_wen,
  input  logic                     id_is_load,
  input  logic                     flush,
  input  logic [DATA_W-1:0]        alu_result,
  input  logic [DATA_W-1:0]        wb_result,
  output logic [NSRC*DATA_W-1:0]   src_out,
  output logic [NSRC*2-1:0]        fwd_sel,
  output logic                     stall,
  output logic [15:0]              stall_cnt,
  output logic [15:0]              fwd_cnt
);

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_ALU = 2'b01;
  localparam logic [1:0] SEL_WB  = 2'b10;

  // Tag slots: S1 = EX/MEM, S2 = MEM/WB
  logic              s1_valid_q, s1_valid_d;
  logic [ADDR_W-1:0] s1_addr_q,  s1_addr_d;
  logic              s1_load_q,  s1_load_d;
  logic              s2_valid_q;
  logic [ADDR_W-1:0] s2_addr_q;
  logic              s2_load_q;

  logic              hazard_c;

  // Per-source select and data mux; S1 is the newer writer so it wins.
  // A loaded value in S1 is not yet available, so that source stays on 00.
  always_comb begin
    logic [ADDR_W-1:0] src_a;
    logic              hit1;
    logic              hit2;
    logic [1:0]        sel;
    fwd_sel  = '0;
    src_out  = '0;
    hazard_c = 1'b0;
    src_a    = '0;
    hit1     = 1'b0;
    hit2     = 1'b0;
    sel      = SEL_RF;
    for (int unsigned i = 0; i < NSRC; i++) begin
      src_a = id_src_addr[i*ADDR_W +: ADDR_W];
      hit1  = s1_valid_q && (s1_addr_q == src_a);
      hit2  = s2_valid_q && (s2_addr_q == src_a);
      sel   = SEL_RF;
      if (hit1) begin
        if (s1_load_q) hazard_c = 1'b1;
        else           sel      = SEL_ALU;
      end else if (hit2) begin
        sel = SEL_WB;
      end
      fwd_sel[i*2 +: 2] = sel;
      case (sel)
        SEL_ALU: src_out[i*DATA_W +: DATA_W] = alu_result;
        SEL_WB:  src_out[i*DATA_W +: DATA_W] = wb_result;
        default: src_out[i*DATA_W +: DATA_W] = id_src_data[i*DATA_W +: DATA_W];
      endcase
    end
    // flush kills the consumer, so it overrides the hazard
    stall = id_valid && !flush && hazard_c;
  end

  // Next S1 tag: stalled or flushed instructions enter EX as a bubble
  always_comb begin
    s1_valid_d = id_valid && id_wen && !flush && !stall;
    s1_addr_d  = id_dst_addr;
    s1_load_d  = id_is_load;
  end

  // Slot registers; S2 always follows S1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_addr_q  <= '0;
      s1_load_q  <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_addr_q  <= '0;
      s2_load_q  <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_addr_q  <= s1_addr_d;
      s1_load_q  <= s1_load_d;
      s2_valid_q <= s1_valid_q;
      s2_addr_q  <= s1_addr_q;
      s2_load_q  <= s1_load_q;
    end
  end

`ifdef BYPASS_PERF_CNT_EN
  localparam int unsigned CNT_W = 16;

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] fwd_cnt_q,   fwd_cnt_d;
  logic             any_fwd_c;

  // 11 is never driven, so any set select bit means a forwarded source
  always_comb begin
    any_fwd_c   = |fwd_sel;
    stall_cnt_d = stall_cnt_q;
    fwd_cnt_d   = fwd_cnt_q;
    if (stall && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (id_valid && any_fwd_c && (fwd_cnt_q != '1))
      fwd_cnt_d = fwd_cnt_q + CNT_W'(1);
  end

  // Saturating counters, cleared only by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      fwd_cnt_q   <= fwd_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign fwd_cnt   = fwd_cnt_q;
`else
  assign stall_cnt = '0;
  assign fwd_cnt   = '0;
`endif

endmodule

// File: tb/tb_operand_bypass_unit.sv
// ---------------------------------------------------------------------------
// tb_operand_bypass_unit
// Scoreboard bench: the driver issues one decode cycle per clock, computes the
// expected response from a history of in-flight writers and queues it; a
// monitor on the falling edge pops and compares against the DUT outputs.
// ---------------------------------------------------------------------------
module tb_operand_bypass_unit;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 3;
  localparam int unsigned NSRC   = 2;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   id_valid;
  logic [NSRC*ADDR_W-1:0] id_src_addr;
  logic [NSRC*DATA_W-1:0] id_src_data;
  logic [ADDR_W-1:0]      id_dst_addr;
  logic                   id_wen;
  logic                   id_is_load;
  logic                   flush;
  logic [DATA_W-1:0]      alu_result;
  logic [DATA_W-1:0]      wb_result;
  logic [NSRC*DATA_W-1:0] src_out;
  logic [NSRC*2-1:0]      fwd_sel;
  logic                   stall;
  logic [15:0]            stall_cnt;
  logic [15:0]            fwd_cnt;

  always #5 clk = ~clk;

  operand_bypass_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NSRC(NSRC)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src_addr(id_src_addr),
    .id_src_data(id_src_data), .id_dst_addr(id_dst_addr), .id_wen(id_wen),
    .id_is_load(id_is_load), .flush(flush), .alu_result(alu_result),
    .wb_result(wb_result), .src_out(src_out), .fwd_sel(fwd_sel),
    .stall(stall), .stall_cnt(stall_cnt), .fwd_cnt(fwd_cnt)
  );

  // In-flight writer record; index 0 of the history is the newest
  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic              load;
  } wr_t;

  typedef struct {
    logic        stall;
    logic        chk;
    logic [3:0]  sel;
    logic [15:0] out;
    logic [15:0] scnt;
    logic [15:0] fcnt;
    int          cyc;
  } exp_t;

  wr_t  hist[$];
  exp_t exp_q[$];
  int   m_scnt = 0;
  int   m_fcnt = 0;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input int c, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, c, act, exp);
    end
  endtask

  // One decode cycle: drive inputs, predict outputs, advance the model
  task automatic step(input logic v, input logic [2:0] a0, input logic [2:0] a1,
                      input logic [7:0] d0, input logic [7:0] d1,
                      input logic [2:0] dst, input logic wen, input logic ld,
                      input logic fl, input logic [7:0] alu, input logic [7:0] wb,
                      input logic r);
    exp_t        e;
    logic        hz;
    logic        found;
    logic [2:0]  a;
    logic [1:0]  s;
    logic [7:0]  o;
    wr_t         w;
    @(posedge clk);
    #1;
    rst         = r;
    id_valid    = v;
    id_src_addr = {a1, a0};
    id_src_data = {d1, d0};
    id_dst_addr = dst;
    id_wen      = wen;
    id_is_load  = ld;
    flush       = fl;
    alu_result  = alu;
    wb_result   = wb;
    cyc++;
    if (r) begin
      hist   = '{wr_t'(0), wr_t'(0)};
      m_scnt = 0;
      m_fcnt = 0;
    end
    e.scnt = 16'(m_scnt);
    e.fcnt = 16'(m_fcnt);
    e.sel  = '0;
    e.out  = '0;
    hz     = 1'b0;
    for (int i = 0; i < 2; i++) begin
      a     = (i == 0) ? a0 : a1;
      s     = 2'b00;
      o     = (i == 0) ? d0 : d1;
      found = 1'b0;
      // the newest in-flight writer of this register decides the source
      for (int k = 0; k < 2; k++) begin
        if (!found && hist[k].valid && hist[k].addr == a) begin
          found = 1'b1;
          if (k == 0 && hist[k].load) hz = 1'b1;
          else if (k == 0) begin s = 2'b01; o = alu; end
          else begin s = 2'b10; o = wb; end
        end
      end
      e.sel[2*i +: 2] = s;
      e.out[8*i +: 8] = o;
    end
    e.stall = v && !fl && hz;
    e.chk   = v;
    e.cyc   = cyc;
`ifdef BYPASS_PERF_CNT_EN
    if (!r && e.stall && m_scnt < 65535) m_scnt++;
    if (!r && v && e.sel != 4'b0 && m_fcnt < 65535) m_fcnt++;
`else
    e.scnt = 16'h0;
    e.fcnt = 16'h0;
`endif
    exp_q.push_back(e);
    if (!r) begin
      w.valid = v && wen && !fl && !e.stall;
      w.addr  = dst;
      w.load  = ld;
      void'(hist.pop_back());
      hist.push_front(w);
    end
  endtask

  // Monitor: compare DUT outputs against the queued expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("stall", e.cyc, {15'h0, stall}, {15'h0, e.stall});
        check("stall_cnt", e.cyc, stall_cnt, e.scnt);
        check("fwd_cnt", e.cyc, fwd_cnt, e.fcnt);
        if (e.chk) begin
          check("fwd_sel", e.cyc, {12'h0, fwd_sel}, {12'h0, e.sel});
          check("src_out", e.cyc, src_out, e.out);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; id_valid = 1'b0; id_src_addr = '0; id_src_data = '0;
    id_dst_addr = '0; id_wen = 1'b0; id_is_load = 1'b0; flush = 1'b0;
    alu_result = '0; wb_result = '0;
    hist = '{wr_t'(0), wr_t'(0)};

    // reset state
    step(1, 3, 5, 8'h11, 8'h22, 0, 0, 0, 0, 8'hAA, 8'hBB, 1);
    step(1, 3, 5, 8'h11, 8'h22, 0, 0, 0, 0, 8'hAA, 8'hBB, 1);
    // no hazard
    step(1, 3, 5, 8'h11, 8'h22, 0, 0, 0, 0, 8'hAA, 8'hBB, 0);
    // EX forward then WB forward of r2
    step(1, 6, 7, 8'h01, 8'h02, 2, 1, 0, 0, 8'h00, 8'h00, 0);
    step(1, 2, 7, 8'h33, 8'h44, 0, 0, 0, 0, 8'hA5, 8'h5A, 0);
    step(1, 2, 6, 8'h33, 8'h44, 0, 0, 0, 0, 8'h77, 8'hA5, 0);
    // priority: two writers of r4, S1 wins
    step(1, 0, 0, 8'h00, 8'h00, 4, 1, 0, 0, 8'h00, 8'h00, 0);
    step(1, 0, 0, 8'h00, 8'h00, 4, 1, 0, 0, 8'h00, 8'h00, 0);
    step(1, 4, 4, 8'h99, 8'h98, 0, 0, 0, 0, 8'h02, 8'h01, 0);
    // load-use: one stall, then WB forward
    step(1, 0, 0, 8'h00, 8'h00, 1, 1, 1, 0, 8'h00, 8'h00, 0);
    step(1, 1, 0, 8'h10, 8'h20, 5, 1, 0, 0, 8'hC1, 8'hC2, 0);
    step(1, 1, 0, 8'h10, 8'h20, 5, 1, 0, 0, 8'hC1, 8'hC2, 0);
    // flush during hazard
    step(1, 0, 0, 8'h00, 8'h00, 1, 1, 1, 0, 8'h00, 8'h00, 0);
    step(1, 1, 2, 8'h10, 8'h20, 5, 1, 0, 1, 8'hD1, 8'hD2, 0);
    step(1, 1, 5, 8'h10, 8'h20, 6, 1, 0, 0, 8'hD1, 8'hD2, 0);
    // reset while a stall is pending
    step(1, 0, 0, 8'h00, 8'h00, 1, 1, 1, 0, 8'h00, 8'h00, 0);
    step(1, 1, 0, 8'h10, 8'h20, 5, 1, 0, 0, 8'hE1, 8'hE2, 1);
    step(1, 1, 0, 8'h10, 8'h20, 5, 0, 0, 0, 8'hE1, 8'hE2, 1);
    step(1, 1, 0, 8'h10, 8'h20, 5, 0, 0, 0, 8'hE1, 8'hE2, 0);

    // randomized traffic on a small register window to provoke hits
    for (int n = 0; n < 400; n++) begin
      step($urandom_range(0, 9) != 0,
           3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)),
           8'($urandom), 8'($urandom),
           3'($urandom_range(0, 3)),
           $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3,
           $urandom_range(0, 9) == 0,
           8'($urandom), 8'($urandom),
           $urandom_range(0, 99) == 0);
    end

    @(posedge clk);
    @(posedge clk);
    check("drain", cyc, 16'(exp_q.size()), 16'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
